// File: rtl/c17_seq_pkg.sv
// rtl/c17_seq_pkg.sv - shared types and defaults for the c17 stimulus sequencer
package c17_seq_pkg;

   localparam int DEPTH_DEF  = 16;
   localparam int HOLD_W_DEF = 8;
   // The stored hold field is sized for the widest supported HOLD_W; narrower
   // configurations zero-extend on write so the counter logic stays uniform.
   localparam int HOLD_W_MAX = 16;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DRIVE  = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   typedef struct packed {
      logic [4:0]            vec;
      logic [HOLD_W_MAX-1:0] hold;
   } entry_t;

endpackage

// File: rtl/c17_golden.sv
// rtl/c17_golden.sv - combinational c17 reference, vector in, {N23,N22} out
module c17_golden (
   input  logic [4:0] vec,
   output logic [1:0] golden
);

   logic n1, n2, n3, n6, n7;
   logic n10, n11, n16, n19, n22, n23;

   assign {n7, n6, n3, n2, n1} = vec;

   // six-NAND c17 netlist
   always_comb begin
      n10    = ~(n1 & n3);
      n11    = ~(n3 & n6);
      n16    = ~(n2 & n11);
      n19    = ~(n11 & n7);
      n22    = ~(n10 & n16);
      n23    = ~(n16 & n19);
      golden = {n23, n22};
   end

endmodule

// File: rtl/c17_stim_sequencer.sv
// rtl/c17_stim_sequencer.sv - table-driven c17 stimulus sequencer with sampled compare
module c17_stim_sequencer
   import c17_seq_pkg::*;
#(
   parameter  int DEPTH  = DEPTH_DEF,
   parameter  int HOLD_W = HOLD_W_DEF,
   localparam int AW     = $clog2(DEPTH),
   localparam int LW     = AW + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [4:0]        wr_vec,
   input  logic [HOLD_W-1:0] wr_hold,
   input  logic              start,
   input  logic [LW-1:0]     start_len,
   input  logic              abort,
   input  logic [1:0]        dut_out,
   output logic [4:0]        stim,
   output logic              busy,
   output logic              done,
   output logic [LW-1:0]     mismatch_cnt,
   output logic [AW-1:0]     first_err_idx,
   output logic              err
);

   state_t                state, state_nx;
   entry_t                vec_tab [DEPTH];
   logic [AW-1:0]         idx, idx_nx;
   logic [LW-1:0]         len_q;
   logic [HOLD_W_MAX-1:0] hold_cnt;
   logic [1:0]            golden;
   logic                  start_ok, more, mism, wr_ok;

   c17_golden u_golden (
      .vec    (stim),
      .golden (golden)
   );

   assign start_ok = start && (start_len != '0) && (start_len <= LW'(DEPTH));
   assign idx_nx   = idx + AW'(1);
   assign more     = ({1'b0, idx} + LW'(1)) < len_q;
   assign mism     = (dut_out != golden);
   assign wr_ok    = wr_en && ((state == S_IDLE) || (state == S_DONE));

   // vector table: writable only while no run is using it, never reset
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         vec_tab[wr_addr] <= '{vec: wr_vec, hold: HOLD_W_MAX'(wr_hold)};
      end
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // next-state decode; abort wins over every other transition in a run
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (start_ok) state_nx = S_DRIVE;
         S_DRIVE: begin
            if (abort)                 state_nx = S_DONE;
            else if (hold_cnt == '0)   state_nx = S_SAMPLE;
         end
         S_SAMPLE: begin
            if (abort)     state_nx = S_DONE;
            else if (more) state_nx = S_DRIVE;
            else           state_nx = S_DONE;
         end
         S_DONE:   state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   // status outputs decoded straight from state so reset clears them at once
   always_comb begin
      busy = (state == S_DRIVE) || (state == S_SAMPLE);
      done = (state == S_DONE);
   end

   // run datapath: entry index, hold countdown, driven vector and error record
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stim          <= '0;
         idx           <= '0;
         len_q         <= '0;
         hold_cnt      <= '0;
         mismatch_cnt  <= '0;
         first_err_idx <= '0;
         err           <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_ok) begin
                  idx           <= '0;
                  len_q         <= start_len;
                  stim          <= vec_tab[0].vec;
                  hold_cnt      <= vec_tab[0].hold;
                  mismatch_cnt  <= '0;
                  first_err_idx <= '0;
                  err           <= 1'b0;
               end
            end
            S_DRIVE: begin
               if (!abort && (hold_cnt != '0)) hold_cnt <= hold_cnt - HOLD_W_MAX'(1);
            end
            S_SAMPLE: begin
               if (!abort) begin
                  if (mism) begin
                     if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + LW'(1);
                     if (!err) first_err_idx <= idx;
                     err <= 1'b1;
                  end
                  if (more) begin
                     idx      <= idx_nx;
                     stim     <= vec_tab[idx_nx].vec;
                     hold_cnt <= vec_tab[idx_nx].hold;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/c17_stim_sequencer.md
C17_STIM_SEQUENCER -- requirements
Module: c17_stim_sequencer

Interface
REQ-001 Parameter: DEPTH, default 16, number of vector-table entries.
REQ-002 Parameter: HOLD_W, default 8, width of the per-entry hold count.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 wr_en  in  1  table write strobe.
REQ-006 wr_addr  in  log2(DEPTH)  table entry index.
REQ-007 wr_vec  in  5  input vector, bit order {N7,N6,N3,N2,N1}.
REQ-008 wr_hold  in  HOLD_W  hold count for the entry.
REQ-009 start  in  1  run request, one-cycle pulse.
REQ-010 start_len  in  log2(DEPTH)+1  number of entries to run, valid with start.
REQ-011 abort  in  1  terminate the run.
REQ-012 dut_out  in  2  sampled c17 outputs, {N23,N22}.
REQ-013 stim  out  5  drive to the pulse-shaping chains, {N7,N6,N3,N2,N1}.
REQ-014 busy  out  1  run in progress.
REQ-015 done  out  1  one-cycle pulse at run end.
REQ-016 mismatch_cnt  out  log2(DEPTH)+1  count of failed samples.
REQ-017 first_err_idx  out  log2(DEPTH)  entry index of the first mismatch.
REQ-018 err  out  1  sticky flag, set on any mismatch.

Function
REQ-019 FSM states: IDLE, DRIVE, SAMPLE, DONE.
REQ-020 IDLE: start with 1<=start_len<=DEPTH causes IDLE->DRIVE, idx=0, clears mismatch_cnt, err and first_err_idx; start_len of 0 or >DEPTH is ignored.
REQ-021 The table write is accepted only in IDLE or DONE; wr_en in DRIVE or SAMPLE is dropped.
REQ-022 DRIVE: stim=table[idx].vec from the first DRIVE cycle; the hold counter loads table[idx].hold and decrements each cycle; at 0 the FSM moves to SAMPLE, so the entry is held hold+1 cycles before SAMPLE.
REQ-023 SAMPLE, one cycle with stim unchanged: compare dut_out with golden c17(table[idx].vec); on mismatch, increment mismatch_cnt and set err; set first_err_idx only when err was clear.
REQ-024 Golden function: N10=NAND(N1,N3), N11=NAND(N3,N6), N16=NAND(N2,N11), N19=NAND(N11,N7), N22=NAND(N10,N16), N23=NAND(N16,N19).
REQ-025 SAMPLE->DRIVE with idx+1 if idx+1<len; otherwise SAMPLE->DONE.
REQ-026 DONE, one cycle: done=1, then IDLE; stim keeps the last vector until the next run.
REQ-027 busy=1 exactly in DRIVE and SAMPLE.
REQ-028 mismatch_cnt saturates at its maximum; no wrap.
REQ-029 abort in DRIVE or SAMPLE moves to DONE the next cycle; a SAMPLE compare in the abort cycle is discarded; abort has priority over start.
REQ-030 start while busy is ignored.
REQ-031 A write to the entry currently being driven is impossible per REQ-021; table contents persist across runs.

Reset
REQ-032 On rst assertion, immediately: state=IDLE; stim=0; busy=0; done=0; mismatch_cnt=0; first_err_idx=0; err=0; idx and hold counter=0.
REQ-033 Table contents are not reset; reset mid-run abandons the run with no done pulse.

Structure
REQ-034 Package c17_seq_pkg holds the state enum, the DEPTH/HOLD_W defaults and the table entry struct {vec[4:0], hold}.
REQ-035 One sub-module, c17_golden, is purely combinational: 5-bit vector in, expected {N23,N22} out.

Verification
REQ-036 Single entry vec=5'b00000, hold=3, start_len=1, dut_out=2'b00 -> stim=0 for 5 cycles (4 DRIVE + 1 SAMPLE), done pulse, mismatch_cnt=0, err=0.
REQ-037 Entry vec=5'b11111, dut_out forced 2'b00 (golden 2'b01) -> mismatch_cnt=1, err=1, first_err_idx=0.
REQ-038 16 entries covering random vectors, with a fault on entries 5 and 9 -> mismatch_cnt=2, first_err_idx=5, busy high for the sum over entries of (hold+2) cycles.
REQ-039 abort during the SAMPLE of entry 2, with that sample mismatching -> done the next cycle, mismatch_cnt unchanged.
REQ-040 start_len=0 or start_len=17 -> FSM stays in IDLE, no done; wr_en while busy -> table unchanged on readback run.
REQ-041 rst asserted mid-DRIVE -> all outputs at reset values without waiting for a clock edge; next start runs normally.
